// File: rtl/fifol_n_if.sv
// Handshake bundle for the fifol_n buffer: the producer/consumer side is the
// master, the FIFO itself is the slave.
interface fifol_n_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d_in;
  logic             enq;
  logic             deq;
  logic             clr;
  logic [WIDTH-1:0] d_out;
  logic             full_n;
  logic             empty_n;
  logic [CW-1:0]    count;
  logic             almost_full;

  modport master (
    output d_in, enq, deq, clr,
    input  d_out, full_n, empty_n, count, almost_full
  );

  modport slave (
    input  d_in, enq, deq, clr,
    output d_out, full_n, empty_n, count, almost_full
  );
endinterface

// File: rtl/fifol_n.sv
// N-entry L-style FIFO: full_n is relieved combinationally by deq, so a full
// buffer takes an enqueue in the same cycle as a dequeue. Any depth >= 2.
module fifol_n #(
  parameter int WIDTH    = 1,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic       clk_i,
  input logic       rst_n_i,
  fifol_n_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT    = CW'(AF_LEVEL);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full;
  logic             do_deq;
  logic             do_enq;
  logic             wr_en;

  // Explicit wrap so non-power-of-two depths never rely on overflow.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count_q == DEPTH_CNT);
  assign do_deq = bus.deq && (count_q != '0);
  assign do_enq = bus.enq && (!full || do_deq);
  assign wr_en  = do_enq && !bus.clr;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_deq) head_d = ptr_inc(head_q);
      if (do_enq) tail_d = ptr_inc(tail_q);
      if (do_enq && !do_deq)      count_d = count_q + 1'b1;
      else if (do_deq && !do_enq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally not reset; head/tail define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[tail_q] <= bus.d_in;
  end

  assign bus.d_out       = mem_q[head_q];
  assign bus.full_n      = !full || bus.deq;
  assign bus.empty_n     = (count_q != '0);
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= AF_CNT);

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_n_i) begin
      if (bus.deq && !bus.empty_n) $warning("%m: Dequeuing from empty fifo");
      if (bus.enq && !bus.full_n)  $warning("%m: Enqueuing to a full fifo");
    end
  end
`endif
endmodule

// File: tb/tb_fifol_n.sv
// Directed bench for fifol_n: a depth-4 instance for handshake/flush/reset
// behaviour and a depth-3 instance for non-power-of-two wrap ordering.
module tb_fifol_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  fifol_n_if #(.WIDTH(8), .DEPTH(4)) if4 ();
  fifol_n_if #(.WIDTH(8), .DEPTH(3)) if3 ();

  fifol_n #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if4)
  );
  fifol_n #(.WIDTH(8), .DEPTH(3), .AF_LEVEL(2)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if3)
  );

  logic [7:0] q4 [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the depth-4 instance; entered and left at posedge+1.
  task automatic step4(input logic en, input logic dq, input logic cl, input logic [7:0] din);
    logic dd, de;
    if4.enq = en; if4.deq = dq; if4.clr = cl; if4.d_in = din;
    #1;
    chk("full_n4", if4.full_n, (q4.size() != 4) || dq);
    if (q4.size() > 0) chk("dout4_pre", if4.d_out, q4[0]);
    @(posedge clk);
    if (cl) q4.delete();
    else begin
      dd = dq && (q4.size() > 0);
      de = en && ((q4.size() < 4) || dd);
      if (dd) void'(q4.pop_front());
      if (de) q4.push_back(din);
    end
    #1;
    chk("count4", if4.count, q4.size());
    chk("empty_n4", if4.empty_n, q4.size() != 0);
    chk("af4", if4.almost_full, q4.size() >= 3);
    if (q4.size() > 0) chk("dout4_post", if4.d_out, q4[0]);
  endtask

  initial begin
    int nxt, expo, c3;
    logic en, dq;

    if4.enq = 1'b1; if4.deq = 1'b0; if4.clr = 1'b0; if4.d_in = 8'h99;
    if3.enq = 1'b0; if3.deq = 1'b0; if3.clr = 1'b0; if3.d_in = 8'h00;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_empty_n", if4.empty_n, 1'b0);
      chk("rst_full_n", if4.full_n, 1'b1);
      chk("rst_count", if4.count, 0);
      chk("rst_af", if4.almost_full, 1'b0);
    end
    if4.enq = 1'b0;
    rst_n = 1'b1;

    // Fill, then an illegal enqueue while full.
    step4(1, 0, 0, 8'h11);
    step4(1, 0, 0, 8'h22);
    step4(1, 0, 0, 8'h33);
    step4(1, 0, 0, 8'h44);
    step4(1, 0, 0, 8'hEE);

    // Full with simultaneous enq/deq: count holds at 4, order preserved.
    for (int j = 0; j < 10; j++) step4(1, 1, 0, 8'(8'h55 + j));

    for (int j = 0; j < 4; j++) step4(0, 1, 0, 8'h00);
    step4(0, 1, 0, 8'h00);

    // Flush wins over same-cycle enq/deq.
    step4(1, 0, 0, 8'hA1);
    step4(1, 0, 0, 8'hA2);
    step4(1, 1, 1, 8'hA3);
    step4(1, 0, 0, 8'hAA);
    step4(0, 0, 0, 8'h00);

    // Asynchronous reset between edges.
    step4(1, 0, 0, 8'hB1);
    if4.enq = 1'b0; if4.deq = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_empty_n", if4.empty_n, 1'b0);
    chk("async_count", if4.count, 0);
    chk("async_full_n", if4.full_n, 1'b1);
    chk("async_af", if4.almost_full, 1'b0);
    q4.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step4(1, 0, 0, 8'hC1);
    step4(0, 1, 0, 8'h00);

    // Depth-3 stream of 1..20 with random gaps.
    nxt = 1; expo = 1; c3 = 0;
    for (int cyc = 0; cyc < 400 && expo <= 20; cyc++) begin
      dq = (c3 > 0) && ($urandom_range(0, 1) == 1);
      en = (nxt <= 20) && ((c3 < 3) || dq) && ($urandom_range(0, 2) != 0);
      if3.enq = en; if3.deq = dq; if3.d_in = 8'(nxt);
      #1;
      if (dq) chk("wrap_order", if3.d_out, expo);
      chk("wrap_full_n", if3.full_n, (c3 != 3) || dq);
      @(posedge clk);
      if (dq) begin expo++; c3--; end
      if (en) begin nxt++; c3++; end
      #1;
      chk("wrap_count", if3.count, c3);
      chk("wrap_af", if3.almost_full, c3 >= 2);
    end
    if3.enq = 1'b0; if3.deq = 1'b0;
    chk("wrap_done", expo, 21);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifol_n.md
# fifol_n

Parametrised N-entry FIFO that succeeds the single-entry FIFOL1 in the core's inter-stage buffering. It keeps the same L-style handshake: FULL_N is combinationally relieved by DEQ, so a full FIFO accepts an enqueue in the same cycle as a dequeue. It adds configurable depth, an occupancy count, an almost-full flag, and non-power-of-two depths via explicit pointer wrap. It drops in wherever FIFOL1 is used and a deeper skid or decoupling buffer is needed, such as fetch-to-decode or memory response queues.

## Interface
- width, 1, data width in bits (≥1)
- depth, 4, number of entries (≥2; non-power-of-two allowed)
- af_level, depth-1, ALMOST_FULL asserts when occupancy ≥ af_level (1 ≤ af_level ≤ depth)
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset; asynchronous, active-low. One clock; reset is asynchronous and active-low.
- D_IN  in  width  enqueue data
- ENQ  in  1  enqueue strobe; caller guarantees FULL_N=1 when asserted
- DEQ  in  1  dequeue strobe; caller guarantees EMPTY_N=1 when asserted
- CLR  in  1  synchronous flush
- D_OUT  out  width  head entry; valid only while EMPTY_N=1
- FULL_N  out  1  = !full || DEQ (combinational from DEQ)
- EMPTY_N  out  1  occupancy ≠ 0 (registered)
- COUNT  out  $clog2(depth+1)  current occupancy (registered)
- ALMOST_FULL  out  1  COUNT ≥ af_level (decoded from registered COUNT)

## Operation
- State:
  - storage array mem[0..depth-1], not reset;
  - head and tail pointers, each $clog2(depth) bits;
  - count register.
- D_OUT = mem[head], a combinational read of registered storage. There is no bypass: D_IN never appears on D_OUT in the cycle it is enqueued.
- Per posedge, evaluated in priority order:
  - CLR=1: head=tail=count=0. Any same-cycle ENQ/DEQ is discarded.
  - ENQ=1 and DEQ=1 with count≥1: mem[tail]←D_IN, both pointers advance, count unchanged. This is legal at count=depth and is the full-throughput case.
  - ENQ=1 only: mem[tail]←D_IN, tail advances, count+1.
  - DEQ=1 only with count≥1: head advances, count−1.
  - DEQ=1 at count=0: illegal. The dequeue is ignored and state is unchanged except for any same-cycle ENQ, which is then treated as ENQ only.
  - ENQ=1 with FULL_N=0: illegal. The write is suppressed and state is unchanged.
- Pointer advance: if ptr==depth−1 then 0, else ptr+1. No reliance on power-of-two overflow.
- full ≡ (count==depth). Count never exceeds depth or goes below 0.
- Simulation-only checks, excluded from synthesis:
  - warn "Dequeuing from empty fifo" on DEQ while EMPTY_N=0;
  - warn "Enqueuing to a full fifo" on ENQ && !FULL_N.
  - Both warnings use %m.
- No initial blocks are required. Storage contents after reset are don't-care.

## Timing
- Reset (RST=0), applied immediately and asynchronously:
  - count=0, head=tail=0;
  - EMPTY_N=0, FULL_N=1, COUNT=0, ALMOST_FULL=0;
  - D_OUT is don't-care.
- Release of reset is sampled synchronously. The first update occurs at the first posedge with RST=1.
- Reset asserted mid-operation discards all contents. The same-cycle ENQ is lost.
- Latency: ENQ at edge k into an empty FIFO gives EMPTY_N=1 and D_OUT=D_IN(k) after edge k, so data is visible in cycle k+1.
- Throughput: one ENQ and one DEQ per cycle, sustained at any occupancy, including full.
- FULL_N has a combinational path from DEQ. EMPTY_N, COUNT and ALMOST_FULL have no combinational input dependence.
- ALMOST_FULL and COUNT reflect state after the most recent edge. They do not anticipate a same-cycle ENQ/DEQ.
- CLR takes effect on the edge where it is sampled. EMPTY_N=0 in the following cycle.

## Test plan
- Reset: hold RST=0 for 3 cycles with ENQ=1 → EMPTY_N=0, FULL_N=1, COUNT=0, ALMOST_FULL=0 throughout. Assert RST=0 asynchronously between edges → outputs change without waiting for a clock edge.
- Fill and drain: depth=4, width=8. Enqueue 0x11, 0x22, 0x33, 0x44 → COUNT=4, FULL_N=0 with DEQ=0, ALMOST_FULL=1 from COUNT=3. Then dequeue 4 → D_OUT sequence 0x11, 0x22, 0x33, 0x44, EMPTY_N=0 after the 4th.
- Full-and-DEQ: at COUNT=4, DEQ=1 → FULL_N=1 in the same cycle. Drive ENQ=1 with 0x55 → COUNT stays 4 and 0x55 dequeues 4 reads later. Repeat for 10 cycles with no loss or reorder.
- Wrap with non-power-of-two: depth=3. Stream values 1..20 with random ENQ/DEQ gaps → output order 1..20 exactly, pointers wrap 2→0, COUNT never exceeds 3.
- Flush priority: COUNT=2, then CLR=1 with ENQ=1 and DEQ=1 in the same cycle → next cycle COUNT=0, EMPTY_N=0. The next ENQ of 0xAA appears on D_OUT one cycle later.
- Illegal ops: DEQ at COUNT=0 → warning printed, COUNT stays 0. ENQ with FULL_N=0 → warning printed, contents and COUNT unchanged.
